// File: rtl/pi_seq_pkg.sv
// pi_seq_pkg: shared types, widths and saturation helper
// for the PI request sequencer and other FOC blocks.
package pi_seq_pkg;

  localparam int DW = 16;
  localparam int CW = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } pi_seq_state_t;

  function automatic logic signed [DW-1:0] sat16(
    input logic signed [DW:0] x
  );
    logic signed [DW:0] hi;
    logic signed [DW:0] lo;
    hi = 17'sh07FFF;
    lo = -17'sh08000;
    if (x > hi)
      return 16'sh7FFF;
    else if (x < lo)
      return 16'sh8000;
    else
      return x[DW-1:0];
  endfunction

endpackage

// File: rtl/pi_setpoint_ramp.sv
// pi_setpoint_ramp: registered setpoint moving toward
// the target by at most step per load; step 0 jumps.
module pi_setpoint_ramp
  import pi_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic signed [DW-1:0] target,
  input  logic        [DW-1:0] step,
  output logic signed [DW-1:0] aim
);

  logic signed [DW:0]   d;
  logic signed [DW:0]   step_s;
  logic signed [DW:0]   aim_s;
  logic signed [DW-1:0] nxt;

  // next aim: clamp the 17-bit difference to +/-step
  always_comb begin
    aim_s  = {aim[DW-1], aim};
    step_s = signed'({1'b0, step});
    d      = {target[DW-1], target} - aim_s;
    nxt    = target;
    if (step != '0) begin
      if (d > step_s)
        nxt = sat16(aim_s + step_s);
      else if (d < -step_s)
        nxt = sat16(aim_s - step_s);
    end
  end

  // aim register, updated only on an accepted sample
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      aim <= '0;
    else if (load)
      aim <= nxt;
  end

endmodule

// File: rtl/pi_request_sequencer.sv
// pi_request_sequencer: one PI request per sample, ramped aim,
// response timeout. Option macro: PI_SEQ_OVERRUN_CNT_EN.
module pi_request_sequencer
  import pi_seq_pkg::*;
#(
  parameter logic [DW-1:0] STEP    = 16'd64,
  parameter logic [CW-1:0] TIMEOUT = 8'd15
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_sample_en,
  input  logic signed [DW-1:0] i_sample,
  input  logic signed [DW-1:0] i_target,
  output logic                 o_pi_en,
  output logic signed [DW-1:0] o_pi_aim,
  output logic signed [DW-1:0] o_pi_real,
  input  logic                 i_pi_en,
  input  logic signed [DW-1:0] i_pi_value,
  output logic                 o_en,
  output logic signed [DW-1:0] o_value,
  output logic                 o_busy,
  output logic                 o_timeout,
  output logic        [DW-1:0] o_overrun_cnt
);

  pi_seq_state_t state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          drop;

  assign accept = (state == IDLE) && i_sample_en;
  assign drop   = (state == WAIT) && i_sample_en;
  assign o_busy = (state != IDLE);

  pi_setpoint_ramp u_ramp (
    .clk    (clk),
    .rstn   (rstn),
    .load   (accept),
    .target (i_target),
    .step   (STEP),
    .aim    (o_pi_aim)
  );

  // request/response FSM with registered strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      o_pi_en   <= 1'b0;
      o_pi_real <= '0;
      o_en      <= 1'b0;
      o_value   <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_pi_en   <= 1'b0;
      o_en      <= 1'b0;
      o_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_sample_en) begin
            o_pi_real <= i_sample;
            o_pi_en   <= 1'b1;
            cnt       <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (i_pi_en) begin
            o_value <= i_pi_value;
            o_en    <= 1'b1;
            state   <= IDLE;
          end else if (cnt == TIMEOUT) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PI_SEQ_OVERRUN_CNT_EN
  // saturating count of samples dropped while busy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      o_overrun_cnt <= '0;
    else if (drop && (o_overrun_cnt != 16'hFFFF))
      o_overrun_cnt <= o_overrun_cnt + 1'b1;
  end
`else
  logic unused_drop;
  assign unused_drop   = drop;
  assign o_overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_pi_request_sequencer.sv
// tb_pi_request_sequencer: directed steps with
// hand-computed expectations; STEP=64 and STEP=0 instances.
module tb_pi_request_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sample_en;
  logic [15:0] sample;
  logic [15:0] target;
  logic        pi_en_in;
  logic [15:0] pi_val;

  logic        pi_en_a, en_a, busy_a, to_a;
  logic [15:0] aim_a, real_a, val_a, ovr_a;
  logic        pi_en_b, en_b, busy_b, to_b;
  logic [15:0] aim_b, real_b, val_b, ovr_b;

  int total = 0;
  int bad   = 0;
  logic seen;
  logic [15:0] exp_ovr;

  always #5 clk = ~clk;

  pi_request_sequencer #(.STEP(16'd64), .TIMEOUT(8'd15)) u_dut (
    .clk(clk), .rstn(rstn),
    .i_sample_en(sample_en), .i_sample(sample), .i_target(target),
    .o_pi_en(pi_en_a), .o_pi_aim(aim_a), .o_pi_real(real_a),
    .i_pi_en(pi_en_in), .i_pi_value(pi_val),
    .o_en(en_a), .o_value(val_a), .o_busy(busy_a),
    .o_timeout(to_a), .o_overrun_cnt(ovr_a)
  );

  pi_request_sequencer #(.STEP(16'd0), .TIMEOUT(8'd15)) u_dut0 (
    .clk(clk), .rstn(rstn),
    .i_sample_en(sample_en), .i_sample(sample), .i_target(target),
    .o_pi_en(pi_en_b), .o_pi_aim(aim_b), .o_pi_real(real_b),
    .i_pi_en(pi_en_in), .i_pi_value(pi_val),
    .o_en(en_b), .o_value(val_b), .o_busy(busy_b),
    .o_timeout(to_b), .o_overrun_cnt(ovr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_sample(input logic [15:0] s, input logic [15:0] t);
    sample_en = 1'b1;
    sample    = s;
    target    = t;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic respond(input logic [15:0] v);
    pi_en_in = 1'b1;
    pi_val   = v;
    tick();
    pi_en_in = 1'b0;
  endtask

  initial begin
    logic [15:0] ramp_exp [4];
    ramp_exp[0] = 16'd64;
    ramp_exp[1] = 16'd128;
    ramp_exp[2] = 16'd192;
    ramp_exp[3] = 16'd200;

    rstn = 1'b0; sample_en = 1'b0; sample = '0; target = '0;
    pi_en_in = 1'b0; pi_val = '0;
    tick(); tick();
    chk("rst_pi_en", {15'd0, pi_en_a}, 16'd0);
    chk("rst_aim", aim_a, 16'd0);
    chk("rst_real", real_a, 16'd0);
    chk("rst_value", val_a, 16'd0);
    chk("rst_busy", {15'd0, busy_a}, 16'd0);
    chk("rst_ovr", ovr_a, 16'd0);
    rstn = 1'b1;
    tick();

    // 1: ramp 0 -> 200 in steps of 64
    for (int k = 0; k < 4; k++) begin
      do_sample(16'(k + 1), 16'd200);
      chk("ramp_pi_en", {15'd0, pi_en_a}, 16'd1);
      chk("ramp_aim", aim_a, ramp_exp[k]);
      chk("ramp_real", real_a, 16'(k + 1));
      respond(16'h0010);
      chk("ramp_resp_en", {15'd0, en_a}, 16'd1);
      chk("ramp_pi_en_low", {15'd0, pi_en_a}, 16'd0);
    end

    // 2: STEP=0 jumps 32767 -> -32768 without wrap
    do_sample(16'h0005, 16'h7FFF);
    chk("jump_hi_b", aim_b, 16'h7FFF);
    chk("slew_hi_a", aim_a, 16'd264);
    respond(16'h0020);
    do_sample(16'h0006, 16'h8000);
    chk("jump_lo_b", aim_b, 16'h8000);
    chk("slew_lo_a", aim_a, 16'd200);
    respond(16'h0030);

    // 3: response 6 edges after accept
    do_sample(16'h0111, 16'd200);
    chk("resp_pi_en", {15'd0, pi_en_a}, 16'd1);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen = seen | en_a | to_a | pi_en_a;
    end
    chk("resp_quiet", {15'd0, seen}, 16'd0);
    chk("resp_busy", {15'd0, busy_a}, 16'd1);
    respond(16'h1234);
    chk("resp_en", {15'd0, en_a}, 16'd1);
    chk("resp_value", val_a, 16'h1234);
    chk("resp_busy_low", {15'd0, busy_a}, 16'd0);
    tick();
    chk("resp_en_pulse", {15'd0, en_a}, 16'd0);

    // 4: timeout with no response
    do_sample(16'h0222, 16'd200);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      seen = seen | to_a | en_a;
    end
    chk("to_early", {15'd0, seen}, 16'd0);
    tick();
    chk("to_pulse", {15'd0, to_a}, 16'd1);
    chk("to_no_en", {15'd0, en_a}, 16'd0);
    chk("to_value", val_a, 16'h1234);
    chk("to_busy", {15'd0, busy_a}, 16'd0);
    do_sample(16'h0333, 16'd200);
    chk("to_next_acc", {15'd0, pi_en_a}, 16'd1);
    chk("to_pulse_end", {15'd0, to_a}, 16'd0);
    respond(16'h0040);

    // 5: three samples while waiting are dropped
    do_sample(16'h0444, 16'd200);
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      do_sample(16'h0555, 16'h0900);
      seen = seen | pi_en_a;
    end
    chk("drop_no_req", {15'd0, seen}, 16'd0);
    chk("drop_real", real_a, 16'h0444);
    chk("drop_aim", aim_a, 16'd200);
    respond(16'h0050);
`ifdef PI_SEQ_OVERRUN_CNT_EN
    exp_ovr = 16'd3;
`else
    exp_ovr = 16'd0;
`endif
    chk("drop_ovr", ovr_a, exp_ovr);

    // 6: reset mid-wait, then stray response
    do_sample(16'h0666, 16'd200);
    tick(); tick();
    rstn = 1'b0;
    #2;
    chk("mid_rst_busy", {15'd0, busy_a}, 16'd0);
    chk("mid_rst_aim", aim_a, 16'd0);
    chk("mid_rst_real", real_a, 16'd0);
    chk("mid_rst_value", val_a, 16'd0);
    chk("mid_rst_ovr", ovr_a, 16'd0);
    #4;
    rstn = 1'b1;
    respond(16'h5555);
    chk("stray_en", {15'd0, en_a}, 16'd0);
    chk("stray_value", val_a, 16'd0);
    chk("stray_busy", {15'd0, busy_a}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
